noc_local_ni: RTL and testbench

- Network interface for a processing-element core, attached to a router's local port.
- It is the other end of the router's L_ifc link:
  - Transmits single-flit packets into the router's local input port using credit-based flow control.
  - Receives flits from the router's local output port into a small buffer.
  - Returns one credit per flit the core consumes.
- The core sees simple valid/ready streams on both sides.

---
 rtl/noc_pkg.sv | 13 +
 rtl/noc_ni_rx_fifo.sv | 56 +++++
 rtl/noc_local_ni.sv | 97 +++++++++
 tb/tb_noc_local_ni.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared flit format and widths for the local network interface.
package noc_pkg;

  localparam int FLIT_W  = 16;
  localparam int COORD_W = 4;

  typedef struct packed {
    logic [7:0]         payload;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
  } flit_t;

endpackage

// File: rtl/noc_ni_rx_fifo.sv
// Receive buffer for flits arriving from the router's local output port.
module noc_ni_rx_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  flit_t push_data,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output flit_t head,
  output logic  overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  flit_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == (PTR_W + 1)'(DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full buffer is accepted when paired with a pop.
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface: credit-based TX into the router's local input port,
// buffered RX returning one credit for every flit the core consumes.
module noc_local_ni
  import noc_pkg::*;
#(
  parameter logic [COORD_W-1:0] XCOORD   = 4'd0,
  parameter logic [COORD_W-1:0] YCOORD   = 4'd0,
  parameter int                 CREDITS  = 4,
  parameter int                 RX_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tx_valid_i,
  input  logic [COORD_W-1:0]           tx_dest_x_i,
  input  logic [COORD_W-1:0]           tx_dest_y_i,
  input  logic [7:0]                   tx_payload_i,
  output logic                         tx_ready_o,
  output logic [FLIT_W-1:0]            net_data_o,
  output logic                         net_enable_o,
  input  logic                         net_credit_i,
  input  logic [FLIT_W-1:0]            net_data_i,
  input  logic                         net_enable_i,
  output logic                         net_credit_o,
  output logic                         rx_valid_o,
  output logic [7:0]                   rx_payload_o,
  output logic                         rx_misroute_o,
  input  logic                         rx_ready_i,
  output logic [$clog2(CREDITS+1)-1:0] tx_credits_o,
  output logic [1:0]                   err_o
);

  localparam int CNT_W = $clog2(CREDITS + 1);

  logic [CNT_W-1:0] credits;
  logic             tx_fire;
  logic             rx_pop;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_overflow;
  flit_t            rx_in;
  flit_t            rx_head;
  flit_t            tx_flit;

  assign tx_credits_o = credits;
  assign tx_ready_o   = (credits != '0);
  assign tx_fire      = tx_valid_i & tx_ready_o;

  assign tx_flit.payload = tx_payload_i;
  assign tx_flit.dest_x  = tx_dest_x_i;
  assign tx_flit.dest_y  = tx_dest_y_i;

  assign rx_in         = net_data_i;
  assign rx_valid_o    = ~rx_empty;
  assign rx_pop        = rx_valid_o & rx_ready_i;
  assign rx_payload_o  = rx_valid_o ? rx_head.payload : 8'h00;
  assign rx_misroute_o = rx_valid_o &
                         ((rx_head.dest_x != XCOORD) | (rx_head.dest_y != YCOORD));

  noc_ni_rx_fifo #(
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (net_enable_i),
    .push_data(rx_in),
    .pop      (rx_pop),
    .full     (rx_full),
    .empty    (rx_empty),
    .head     (rx_head),
    .overflow (rx_overflow)
  );

  // A send and a returned credit in the same cycle cancel; a credit beyond CREDITS is a router fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits      <= CNT_W'(CREDITS);
      net_enable_o <= 1'b0;
      net_data_o   <= '0;
      net_credit_o <= 1'b0;
      err_o        <= 2'b00;
    end else begin
      net_enable_o <= tx_fire;
      net_credit_o <= rx_pop;
      if (tx_fire) net_data_o <= tx_flit;
      case ({tx_fire, net_credit_i})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CNT_W'(CREDITS)) err_o[0] <= 1'b1;
          else                            credits  <= credits + 1'b1;
        end
        default: ;
      endcase
      if (rx_overflow) err_o[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_local_ni.sv
// Table-driven bench for noc_local_ni at node (0,0) with four credits and a four-entry RX buffer.
module tb_noc_local_ni;

  typedef struct packed {
    logic        txv;
    logic [7:0]  pl;
    logic [3:0]  dx;
    logic [3:0]  dy;
    logic        cri;
    logic        nen;
    logic [15:0] nd;
    logic        rrdy;
  } stim_t;

  typedef struct packed {
    logic        rdy;
    logic        en;
    logic [15:0] data;
    logic [2:0]  cr;
    logic        cro;
    logic        val;
    logic [7:0]  pl;
    logic        mis;
    logic [1:0]  err;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_valid_i;
  logic [3:0]  tx_dest_x_i;
  logic [3:0]  tx_dest_y_i;
  logic [7:0]  tx_payload_i;
  logic        tx_ready_o;
  logic [15:0] net_data_o;
  logic        net_enable_o;
  logic        net_credit_i;
  logic [15:0] net_data_i;
  logic        net_enable_i;
  logic        net_credit_o;
  logic        rx_valid_o;
  logic [7:0]  rx_payload_o;
  logic        rx_misroute_o;
  logic        rx_ready_i;
  logic [2:0]  tx_credits_o;
  logic [1:0]  err_o;

  int   checks = 0;
  int   passed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  noc_local_ni #(
    .XCOORD  (4'd0),
    .YCOORD  (4'd0),
    .CREDITS (4),
    .RX_DEPTH(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_valid_i   (tx_valid_i),
    .tx_dest_x_i  (tx_dest_x_i),
    .tx_dest_y_i  (tx_dest_y_i),
    .tx_payload_i (tx_payload_i),
    .tx_ready_o   (tx_ready_o),
    .net_data_o   (net_data_o),
    .net_enable_o (net_enable_o),
    .net_credit_i (net_credit_i),
    .net_data_i   (net_data_i),
    .net_enable_i (net_enable_i),
    .net_credit_o (net_credit_o),
    .rx_valid_o   (rx_valid_o),
    .rx_payload_o (rx_payload_o),
    .rx_misroute_o(rx_misroute_o),
    .rx_ready_i   (rx_ready_i),
    .tx_credits_o (tx_credits_o),
    .err_o        (err_o)
  );

  function automatic stim_t st(logic txv, logic [7:0] pl, logic [3:0] dx, logic [3:0] dy,
                               logic cri, logic nen, logic [15:0] nd, logic rrdy);
    st = '{txv, pl, dx, dy, cri, nen, nd, rrdy};
  endfunction

  function automatic exp_t ex(logic rdy, logic en, logic [15:0] data, logic [2:0] cr,
                              logic cro, logic val, logic [7:0] pl, logic mis, logic [1:0] err);
    ex = '{rdy, en, data, cr, cro, val, pl, mis, err};
  endfunction

  task automatic add(input stim_t s, input exp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input stim_t s);
    tx_valid_i   = s.txv;
    tx_payload_i = s.pl;
    tx_dest_x_i  = s.dx;
    tx_dest_y_i  = s.dy;
    net_credit_i = s.cri;
    net_enable_i = s.nen;
    net_data_i   = s.nd;
    rx_ready_i   = s.rrdy;
  endtask

  task automatic checkOutput(input string name, input exp_t want);
    exp_t got;
    got = '{tx_ready_o, net_enable_o, net_data_o, tx_credits_o, net_credit_o,
            rx_valid_o, rx_payload_o, rx_misroute_o, err_o};
    checks++;
    if (got === want) passed++;
    else $display("[TB] FAIL %s: actual rdy=%0b en=%0b data=%h cr=%0d cro=%0b val=%0b pl=%h mis=%0b err=%b, required rdy=%0b en=%0b data=%h cr=%0d cro=%0b val=%0b pl=%h mis=%0b err=%b",
                  name, got.rdy, got.en, got.data, got.cr, got.cro, got.val, got.pl, got.mis, got.err,
                  want.rdy, want.en, want.data, want.cr, want.cro, want.val, want.pl, want.mis, want.err);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout, required self-termination");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t idle;
    exp_t  rst_exp;
    idle    = st(0, 8'h00, 4'd0, 4'd0, 0, 0, 16'h0000, 0);
    rst_exp = ex(1, 0, 16'h0000, 3'd4, 0, 0, 8'h00, 0, 2'b00);

    // TX: four sends drain the credits, then credit return, own-node destination and saturation
    add(st(1, 8'hA1, 4'd2, 4'd3, 0, 0, 16'h0, 0), ex(1, 1, 16'hA123, 3'd3, 0, 0, 8'h00, 0, 2'b00));
    add(st(1, 8'hA2, 4'd2, 4'd3, 0, 0, 16'h0, 0), ex(1, 1, 16'hA223, 3'd2, 0, 0, 8'h00, 0, 2'b00));
    add(st(1, 8'hA3, 4'd2, 4'd3, 0, 0, 16'h0, 0), ex(1, 1, 16'hA323, 3'd1, 0, 0, 8'h00, 0, 2'b00));
    add(st(1, 8'hA4, 4'd2, 4'd3, 0, 0, 16'h0, 0), ex(0, 1, 16'hA423, 3'd0, 0, 0, 8'h00, 0, 2'b00));
    add(st(1, 8'hB5, 4'd2, 4'd3, 0, 0, 16'h0, 0), ex(0, 0, 16'hA423, 3'd0, 0, 0, 8'h00, 0, 2'b00));
    add(st(0, 8'h00, 4'd0, 4'd0, 1, 0, 16'h0, 0), ex(1, 0, 16'hA423, 3'd1, 0, 0, 8'h00, 0, 2'b00));
    add(st(1, 8'hA5, 4'd2, 4'd3, 0, 0, 16'h0, 0), ex(0, 1, 16'hA523, 3'd0, 0, 0, 8'h00, 0, 2'b00));
    add(st(0, 8'h00, 4'd0, 4'd0, 1, 0, 16'h0, 0), ex(1, 0, 16'hA523, 3'd1, 0, 0, 8'h00, 0, 2'b00));
    add(st(0, 8'h00, 4'd0, 4'd0, 1, 0, 16'h0, 0), ex(1, 0, 16'hA523, 3'd2, 0, 0, 8'h00, 0, 2'b00));
    add(st(1, 8'hC6, 4'd0, 4'd0, 1, 0, 16'h0, 0), ex(1, 1, 16'hC600, 3'd2, 0, 0, 8'h00, 0, 2'b00));
    add(st(0, 8'h00, 4'd0, 4'd0, 1, 0, 16'h0, 0), ex(1, 0, 16'hC600, 3'd3, 0, 0, 8'h00, 0, 2'b00));
    add(st(0, 8'h00, 4'd0, 4'd0, 1, 0, 16'h0, 0), ex(1, 0, 16'hC600, 3'd4, 0, 0, 8'h00, 0, 2'b00));
    add(st(0, 8'h00, 4'd0, 4'd0, 1, 0, 16'h0, 0), ex(1, 0, 16'hC600, 3'd4, 0, 0, 8'h00, 0, 2'b01));
    add(st(1, 8'hD1, 4'd1, 4'd0, 1, 0, 16'h0, 0), ex(1, 1, 16'hD110, 3'd4, 0, 0, 8'h00, 0, 2'b01));

    // RX: fill, overflow drop, drain with credits, empty pop ignored
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h5500, 0), ex(1, 0, 16'hD110, 3'd4, 0, 1, 8'h55, 0, 2'b01));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h5600, 0), ex(1, 0, 16'hD110, 3'd4, 0, 1, 8'h55, 0, 2'b01));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h5700, 0), ex(1, 0, 16'hD110, 3'd4, 0, 1, 8'h55, 0, 2'b01));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h5800, 0), ex(1, 0, 16'hD110, 3'd4, 0, 1, 8'h55, 0, 2'b01));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h5900, 0), ex(1, 0, 16'hD110, 3'd4, 0, 1, 8'h55, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 0, 16'h0000, 1), ex(1, 0, 16'hD110, 3'd4, 1, 1, 8'h56, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 0, 16'h0000, 1), ex(1, 0, 16'hD110, 3'd4, 1, 1, 8'h57, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 0, 16'h0000, 1), ex(1, 0, 16'hD110, 3'd4, 1, 1, 8'h58, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 0, 16'h0000, 1), ex(1, 0, 16'hD110, 3'd4, 1, 0, 8'h00, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 0, 16'h0000, 1), ex(1, 0, 16'hD110, 3'd4, 0, 0, 8'h00, 0, 2'b11));

    // RX: full buffer with simultaneous push and pop, order kept across pointer wrap
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h6100, 0), ex(1, 0, 16'hD110, 3'd4, 0, 1, 8'h61, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h6200, 0), ex(1, 0, 16'hD110, 3'd4, 0, 1, 8'h61, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h6300, 0), ex(1, 0, 16'hD110, 3'd4, 0, 1, 8'h61, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h6400, 0), ex(1, 0, 16'hD110, 3'd4, 0, 1, 8'h61, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h6500, 1), ex(1, 0, 16'hD110, 3'd4, 1, 1, 8'h62, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h6600, 1), ex(1, 0, 16'hD110, 3'd4, 1, 1, 8'h63, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 0, 16'h0000, 1), ex(1, 0, 16'hD110, 3'd4, 1, 1, 8'h64, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 0, 16'h0000, 1), ex(1, 0, 16'hD110, 3'd4, 1, 1, 8'h65, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 0, 16'h0000, 1), ex(1, 0, 16'hD110, 3'd4, 1, 1, 8'h66, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 0, 16'h0000, 1), ex(1, 0, 16'hD110, 3'd4, 1, 0, 8'h00, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 0, 16'h0000, 0), ex(1, 0, 16'hD110, 3'd4, 0, 0, 8'h00, 0, 2'b11));

    // RX: misrouted flit still delivered, then a locally addressed one
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h7712, 0), ex(1, 0, 16'hD110, 3'd4, 0, 1, 8'h77, 1, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h7300, 1), ex(1, 0, 16'hD110, 3'd4, 1, 1, 8'h73, 0, 2'b11));
    add(st(0, 8'h00, 4'd0, 4'd0, 0, 1, 16'h7712, 0), ex(1, 0, 16'hD110, 3'd4, 0, 1, 8'h73, 0, 2'b11));
    add(st(1, 8'hE1, 4'd2, 4'd3, 0, 0, 16'h0000, 1), ex(1, 1, 16'hE123, 3'd3, 1, 1, 8'h77, 1, 2'b11));

    applyStimulus(idle);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", rst_exp);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].e);
    end

    // Asynchronous reset between edges while a TX flit and a credit pulse are in flight
    applyStimulus(idle);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset", rst_exp);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset", rst_exp);

    applyStimulus(st(1, 8'hF0, 4'd2, 4'd3, 0, 0, 16'h0000, 0));
    @(posedge clk);
    #1;
    checkOutput("tx_after_reset", ex(1, 1, 16'hF023, 3'd3, 0, 0, 8'h00, 0, 2'b00));
    applyStimulus(idle);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
